// File: rtl/multdiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: FSM states, opcodes, 32-bit constants.
// Constants only; no logic, no latency, no flow control.
package multdiv_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int          DATA_W  = 32;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam int          ITER    = DATA_W;

endpackage

// File: rtl/negate_w.sv
// Two's-complement negate built as a bitwise inverter followed by an incrementer.
// Combinational, zero latency; no backpressure.
module negate_w #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] inv;

  assign inv = ~in;
  assign out = inv + {{(WIDTH-1){1'b0}}, 1'b1};

endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed multiply (shift-add) / divide (restoring), one bit per clock; RDY WIDTH+1 edges after start.
// No backpressure: a new start at any time aborts the op in flight and restarts with the new operands.
module multdiv_iter
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  logic [1:0]         state;
  logic [CNT_W-1:0]   count;
  logic               op;
  logic               neg_res;
  logic               div_zero;

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   divisor;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;

  logic               start;
  logic [WIDTH-1:0]   neg_a, neg_b, abs_a, abs_b;
  logic [WIDTH:0]     rem_sh, diff;
  logic               trial_ok;
  logic [2*WIDTH-1:0] fix_in, fix_neg, signed_val;
  logic [WIDTH-1:0]   res_nxt;
  logic               exc_nxt;
  logic [WIDTH:0]     prod_top;

  assign start = ctrl_MULT | ctrl_DIV;

  negate_w #(.WIDTH(WIDTH)) u_neg_a (.in(data_operandA), .out(neg_a));
  negate_w #(.WIDTH(WIDTH)) u_neg_b (.in(data_operandB), .out(neg_b));

  // Magnitudes are held unsigned, so |-2^(WIDTH-1)| = 2^(WIDTH-1) is exact.
  assign abs_a = data_operandA[WIDTH-1] ? neg_a : data_operandA;
  assign abs_b = data_operandB[WIDTH-1] ? neg_b : data_operandB;

  // rem < divisor keeps rem_sh < 2*divisor, so the trial difference fits WIDTH+1 signed bits.
  assign rem_sh   = {rem, quo[WIDTH-1]};
  assign diff     = rem_sh - {1'b0, divisor};
  assign trial_ok = ~diff[WIDTH];

  assign fix_in = (op == OP_MULT) ? prod : {{WIDTH{1'b0}}, quo};

  negate_w #(.WIDTH(2*WIDTH)) u_neg_fix (.in(fix_in), .out(fix_neg));

  assign signed_val = neg_res ? fix_neg : fix_in;
  assign prod_top   = signed_val[2*WIDTH-1:WIDTH-1];

  always_comb begin
    res_nxt = signed_val[WIDTH-1:0];
    exc_nxt = 1'b0;
    if (op == OP_MULT) begin
      exc_nxt = ~((&prod_top) | ~(|prod_top));
    end else if (div_zero) begin
      res_nxt = '0;
      exc_nxt = 1'b1;
    end else begin
      // Only INT_MIN / -1 yields a positive quotient with the top bit set.
      exc_nxt = ~neg_res & quo[WIDTH-1];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      count          <= '0;
      op             <= OP_MULT;
      neg_res        <= 1'b0;
      div_zero       <= 1'b0;
      prod           <= '0;
      mcand          <= '0;
      mplier         <= '0;
      divisor        <= '0;
      rem            <= '0;
      quo            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (start) begin
      state    <= ST_RUN;
      count    <= '0;
      op       <= ctrl_MULT ? OP_MULT : OP_DIV;
      neg_res  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div_zero <= (data_operandB == '0);
      prod     <= '0;
      mcand    <= {{WIDTH{1'b0}}, abs_a};
      mplier   <= abs_b;
      divisor  <= abs_b;
      rem      <= '0;
      quo      <= abs_a;
    end else begin
      case (state)
        ST_RUN: begin
          if (op == OP_MULT) begin
            if (mplier[0]) prod <= prod + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end else begin
            rem <= trial_ok ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], trial_ok};
          end
          count <= count + CNT_W'(1);
          if (count == CNT_W'(WIDTH-1)) state <= ST_FIX;
        end
        ST_FIX: begin
          data_result    <= res_nxt;
          data_exception <= exc_nxt;
          state          <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign data_resultRDY = (state == ST_DONE);

endmodule
